// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and the iterative divider.
interface div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_i;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_o;

    modport master (
        output start, op, dividend, divisor, rd_i, kill,
        input  busy, done, result, rd_o
    );

    modport slave (
        input  start, op, dividend, divisor, rd_i, kill,
        output busy, done, result, rd_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit DIV/DIVU/REM/REMU, restoring division, one quotient bit per cycle.
// Define DIV_ZERO_FASTPATH_EN to send zero-divisor requests straight from IDLE to FIN.
module div_unit (
    input  logic clk,
    input  logic reset_n,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state, state_n;
    logic [31:0] quo, rem, den;
    logic [5:0]  cnt;
    logic [4:0]  rd;
    logic        neg_q, neg_r, is_rem, dz;
    logic        accept, sgn, last, fast;
    logic [32:0] shifted, diff;
    logic [31:0] quo_n, rem_n, quo_f, rem_f, abs_a, abs_b;

    assign accept = state == IDLE && bus.start && !bus.kill;
    assign sgn    = !bus.op[0];
    assign abs_a  = sgn && bus.dividend[31] ? -bus.dividend : bus.dividend;
    assign abs_b  = sgn && bus.divisor[31] ? -bus.divisor : bus.divisor;
    assign last   = cnt == 6'd1;

`ifdef DIV_ZERO_FASTPATH_EN
    assign fast = bus.divisor == 32'd0;
`else
    assign fast = 1'b0;
`endif

    // Restoring step: keep the trial difference only when it did not borrow.
    assign shifted = {1'b0, rem[30:0], quo[31]} | {rem[31], 32'd0};
    assign diff    = shifted - {1'b0, den};
    assign rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_n   = {quo[30:0], !diff[32]};
    // A zero divisor leaves |dividend| as remainder, so only the quotient needs forcing.
    assign quo_f   = dz ? 32'hFFFF_FFFF : (neg_q ? -quo_n : quo_n);
    assign rem_f   = neg_r ? -rem_n : rem_n;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        bus.busy = state != IDLE;
        bus.done = state == FIN;
        case (state)
            IDLE:    state_n = accept ? (fast ? FIN : CALC) : IDLE;
            CALC:    state_n = last ? FIN : CALC;
            default: state_n = IDLE;
        endcase
        if (bus.kill)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quo        <= '0;
            rem        <= '0;
            den        <= '0;
            cnt        <= '0;
            rd         <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_rem     <= 1'b0;
            dz         <= 1'b0;
            bus.result <= '0;
            bus.rd_o   <= '0;
        end else if (accept) begin
            quo    <= abs_a;
            rem    <= '0;
            den    <= abs_b;
            cnt    <= 6'd32;
            rd     <= bus.rd_i;
            neg_q  <= sgn && (bus.dividend[31] ^ bus.divisor[31]);
            neg_r  <= sgn && bus.dividend[31];
            is_rem <= bus.op[1];
            dz     <= bus.divisor == 32'd0;
            if (fast) begin
                bus.result <= bus.op[1] ? bus.dividend : 32'hFFFF_FFFF;
                bus.rd_o   <= bus.rd_i;
            end
        end else if (state == CALC && !bus.kill) begin
            quo <= quo_n;
            rem <= rem_n;
            cnt <= cnt - 6'd1;
            if (last) begin
                bus.result <= is_rem ? rem_f : quo_f;
                bus.rd_o   <= rd;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    div_if bus();

    div_unit dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0)
            r = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = o[1] ? 32'd0 : 32'h8000_0000;
        else if (!o[0] && o[1])
            r = $signed(a) % $signed(b);
        else if (!o[0])
            r = $signed(a) / $signed(b);
        else if (o[1])
            r = a % b;
        else
            r = a / b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        bus.rd_i     = r;
    endtask

    task automatic scramble();
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        bus.rd_i     = 5'($urandom);
    endtask

    // Issues in the current cycle (cycle 0), waits for done, checks latency/result/tag and return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        int n;
        int lat;
        lat = (b == 32'd0) ? ZLAT : 33;
        issue(o, a, b, r);
        step();
        scramble();
        n = 1;
        chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_result"}, bus.result, model(o, a, b));
        chk({tag, "_rd"}, 32'(bus.rd_o), 32'(r));
        step();
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        logic        saw_done;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          n;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.kill = 1'b0;
        issue(2'd0, 32'd100, 32'd7, 5'd3);
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_rd", 32'(bus.rd_o), 32'd0);
        scramble();
        reset_n = 1'b1;
        step();

        run_op("div_100_7", 2'b00, 32'd100, 32'd7, 5'd5);
        run_op("rem_100_7", 2'b10, 32'd100, 32'd7, 5'd5);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd10);
        run_op("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 5'd11);
        run_op("remu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd12);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op("divu_z", 2'b01, 32'h1234, 32'd0, 5'd15);
        run_op("remu_z", 2'b11, 32'h1234, 32'd0, 5'd16);
        run_op("div_negz", 2'b00, 32'hFFFF_0000, 32'd0, 5'd17);
        run_op("rem_negz", 2'b10, 32'hFFFF_0000, 32'd0, 5'd18);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), o, a, b, 5'($urandom));
        end

        // kill at cycle 10 aborts; a new start at cycle 11 completes at cycle 44
        issue(2'b00, 32'd1000, 32'd3, 5'd7);
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            scramble();
            saw_done |= bus.done;
        end
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
        saw_done |= bus.done;
        chk("kill_busy_c11", 32'(bus.busy), 32'd0);
        chk("kill_no_done", 32'(saw_done), 32'd0);
        run_op("after_kill", 2'b01, 32'd1000, 32'd3, 5'd8);

        // start coincident with kill in IDLE is not accepted
        issue(2'b00, 32'd50, 32'd5, 5'd1);
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
        scramble();
        chk("kill_start_busy", 32'(bus.busy), 32'd0);

        // second start in cycle 5 is ignored
        issue(2'b00, 32'd77, 32'd8, 5'd21);
        step();
        scramble();
        n = 1;
        while (n < 5) begin
            step();
            n++;
        end
        issue(2'b11, 32'd999, 32'd10, 5'd30);
        step();
        scramble();
        n++;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        chk("ignore_lat", 32'(n), 32'd33);
        chk("ignore_result", bus.result, model(2'b00, 32'd77, 32'd8));
        chk("ignore_rd", 32'(bus.rd_o), 32'd21);
        // kill during FIN keeps the done already asserted
        bus.kill = 1'b1;
        #1;
        chk("kill_fin_done", 32'(bus.done), 32'd1);
        step();
        bus.kill = 1'b0;
        chk("kill_fin_idle", 32'(bus.busy), 32'd0);

        // reset at cycle 20 discards the operation
        issue(2'b01, 32'd12345, 32'd6, 5'd4);
        step();
        scramble();
        saw_done = 1'b0;
        for (int c = 1; c < 20; c++) begin
            step();
            saw_done |= bus.done;
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        chk("rst_mid_rd", 32'(bus.rd_o), 32'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            saw_done |= bus.done;
        end
        chk("rst_mid_no_done", 32'(saw_done), 32'd0);
        run_op("after_rst", 2'b10, 32'hFFFF_FF00, 32'd7, 5'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port start, input, 1, request a division; accepted only in IDLE.
REQ-004 SHALL have port op, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured at accept.
REQ-005 SHALL have port dividend, input, 32, rs1 operand; captured at accept.
REQ-006 SHALL have port divisor, input, 32, rs2 operand; captured at accept.
REQ-007 SHALL have port rd_i, input, 5, destination register tag; captured at accept.
REQ-008 SHALL have port kill, input, 1, pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port busy, output, 1, high while an accepted operation has not yet completed or been killed; execution stage stalls on it.
REQ-010 SHALL have port done, output, 1, one-cycle pulse qualifying result and rd_o.
REQ-011 SHALL have port result, output, 32, quotient or remainder selected by the captured op.
REQ-012 SHALL have port rd_o, output, 5, captured rd_i, valid with done.

Function
REQ-013 SHALL implement states IDLE, CALC, FIN; IDLE->CALC on start & !kill; CALC->FIN after 32 iterations; FIN->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE; start in CALC/FIN SHALL be ignored, captured operands unchanged.
REQ-015 SHALL compute on magnitudes with unsigned restoring division, one quotient bit per cycle, using a 6-bit iteration counter loaded with 32 at accept.
REQ-016 SHALL, for DIV/REM, take absolute values of both operands at accept; negate the quotient when operand signs differ; give the remainder the sign of the dividend.
REQ-017 SHALL apply sign correction in FIN and register result there; done high for exactly the FIN cycle.
REQ-018 Latency: start high in cycle 0 -> busy high cycles 1..33, done high in cycle 33, back in IDLE in cycle 34 and ready to accept start that cycle.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF (signed and unsigned) and remainder equal to the original dividend.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000, remainder 0.
REQ-021 kill in any state SHALL force IDLE on the next edge, with no done pulse; kill coincident with start in IDLE SHALL not accept.
REQ-022 kill coincident with done in FIN SHALL not suppress the done already asserted in that cycle.
REQ-023 result and rd_o SHALL hold their last values outside done; only the done cycle carries meaning.

Reset
REQ-024 reset_n low at a clock edge SHALL force IDLE, busy=0, done=0, result=0, rd_o=0, counter=0, regardless of state.
REQ-025 reset_n low mid-CALC SHALL discard the operation with no done afterwards.

Configuration
REQ-026 Macro DIV_ZERO_FASTPATH_EN: when defined, a zero divisor at accept SHALL go IDLE->FIN directly, making done high in cycle 1 and busy high in cycle 1 only.
REQ-027 Without DIV_ZERO_FASTPATH_EN, zero divisor SHALL take the full 33-cycle latency; result values SHALL be identical to REQ-019 in both builds.

Verification
REQ-028 DIV 100/7 rd_i=5 at cycle 0 -> done cycle 33, result 14, rd_o 5; REM same operands -> 2.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU -> 1.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-031 DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU -> 0x1234; done cycle 1 with macro, cycle 33 without.
REQ-032 start cycle 0, kill cycle 10 -> no done, busy low from cycle 11; start at cycle 11 accepted, done cycle 44.
REQ-033 start in cycle 0, extra start with different operands in cycle 5 -> single done in cycle 33 carrying the cycle-0 operation; reset_n low in cycle 20 -> no done.
